butterfly_collector: RTL
========================

Name: butterfly_collector

Overview:
- Receives the serialized output of the radix-2 butterfly: YA on the y_nd cycle, YB on the following cycle, with the pass-through metadata.
- Converts that stream into single-port write transactions to the stage working memory (YA to addr_a, YB to addr_b).
- Counts butterflies per stage, pulses stage_done after the last one, and flags protocol violations.
- Sits between the butterfly output and the ping-pong data buffer of each FFT stage.

Parameters:
- X_WDTH, 16, width of one real/imag component; data words are 2*X_WDTH, {re, im}.
- LOG_N, 3, log2 of FFT length N; N/2 butterflies per stage.
- M_WDTH, 2*LOG_N, metadata width; must equal 2*LOG_N.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- y  input  2*X_WDTH  butterfly result {re, im}; YA when y_nd=1, YB the cycle after.
- y_nd  input  1  high for exactly one cycle per butterfly, marks YA.
- m_in  input  M_WDTH  metadata valid on the y_nd cycle: m_in[2*LOG_N-1:LOG_N]=addr_a, m_in[LOG_N-1:0]=addr_b.
- clear  input  1  synchronous abort/restart of the current stage.
- wr_en  output  1  memory write strobe.
- wr_addr  output  LOG_N  memory write address.
- wr_data  output  2*X_WDTH  memory write data.
- bf_count  output  LOG_N-1  butterflies fully written in the current stage.
- stage_done  output  1  one-cycle pulse when the last butterfly of a stage is written.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - wr_en=0, wr_addr=0, wr_data=0.
  - bf_count=0, stage_done=0, err=0.
  - FSM=IDLE, latched addr_b=0.
- FSM states:
  - IDLE: on y_nd=1, register wr_en=1, wr_addr=addr_a, wr_data=y; latch addr_b; go to EXPECT_B. Otherwise wr_en=0.
  - EXPECT_B: unconditionally register wr_en=1, wr_addr=latched addr_b, wr_data=y; increment bf_count; return to IDLE.
- Latency: each write appears on the outputs 1 cycle after its input sample. YA is written at t+1 and YB at t+2 for y_nd at t.
- The input rule (y_nd no more often than every 2 cycles) guarantees at most one write per cycle. Back-to-back butterflies therefore give continuous writes.
- y_nd=1 while in EXPECT_B is a protocol error:
  - set err, sticky until reset;
  - the sample is still written as YB to the latched addr_b;
  - that y_nd is ignored and the FSM returns to IDLE.
- bf_count and stage_done:
  - bf_count wraps from N/2-1 to 0 on the YB write of the last butterfly.
  - stage_done=1 in the same cycle that YB write is presented on wr_en (registered together), else 0.
- Arithmetic: none on data; y passes to wr_data bit-exact. Address fields are unsigned and used directly.
- clear=1 has priority over everything except reset:
  - next cycle wr_en=0, FSM=IDLE, bf_count=0, stage_done=0;
  - any pending YB is discarded;
  - a y_nd in the same cycle is dropped;
  - err is not cleared.
- Reset asserted mid-pair (EXPECT_B): outputs clear immediately; after release there is no YB write and the FSM starts in IDLE.
- wr_addr and wr_data hold their last value while wr_en=0; the memory ignores them.

Decomposition:
- Shared include/package holds the metadata field offsets (M_ADDR_A_LSB=LOG_N, M_ADDR_B_LSB=0) and the FSM state encodings (IDLE=0, EXPECT_B=1). The butterfly issuer uses the same offsets to build m_in.
- No sub-module: FSM, counter and write register are in one module of about 150 lines.

Test Plan:
- Reset: hold rst_n=0 with y_nd=1 and random y -> wr_en=0, bf_count=0, stage_done=0, err=0 throughout; outputs clear asynchronously, without waiting for a clock edge.
- Single pair: y_nd at t, y=0x1234_5678, m_in={3'd0,3'd4}; t+1 y=0x0001_FFFF -> t+1: wr_en=1, wr_addr=0, wr_data=0x12345678. t+2: wr_en=1, wr_addr=4, wr_data=0x0001FFFF. t+3: wr_en=0, bf_count=1.
- Full stage (N=8): four pairs with y_nd every 2 cycles, (a,b)=(0,4),(1,5),(2,6),(3,7) -> 8 consecutive writes in that address order. stage_done=1 only with the write to addr 7. bf_count then reads 0. A following stage restarts cleanly.
- Protocol error: y_nd at t and t+1 -> err=1 from t+2 and stays 1. The t+1 sample is written to the latched addr_b. No extra YA write. err survives a later clear.
- Clear: assert clear in the same cycle as y_nd, after 2 completed butterflies -> no write next cycle, bf_count=0, stage_done never pulses. The next valid pair writes normally.
- Reset mid-pair: rst_n low during EXPECT_B, release 3 cycles later -> wr_en=0 throughout and after release. No YB write. The next y_nd produces a normal YA write.

Source files
------------

// File: rtl/butterfly_collector_pkg.sv
// Shared definitions for the butterfly output collector: metadata field
// offsets (also used by the butterfly issuer to build m_in) and FSM states.
package butterfly_collector_pkg;

  // addr_b sits in the low LOG_N bits of the metadata word.
  localparam int unsigned M_ADDR_B_LSB = 0;

  // addr_a sits directly above addr_b, so its LSB equals LOG_N.
  function automatic int unsigned m_addr_a_lsb(input int unsigned log_n);
    return log_n;
  endfunction

  typedef enum logic {
    IDLE     = 1'b0,
    EXPECT_B = 1'b1
  } bfc_state_t;

endpackage

// File: rtl/butterfly_collector.sv
// Collects the serialized YA/YB output of a radix-2 butterfly and turns it
// into single-port memory writes (YA -> addr_a, YB -> addr_b). Counts the
// butterflies of a stage, pulses stage_done on the last YB write and keeps
// a sticky flag for a y_nd that arrives while YB is still expected.
module butterfly_collector
  import butterfly_collector_pkg::*;
#(
  parameter int X_WDTH = 16,
  parameter int LOG_N  = 3,
  parameter int M_WDTH = 2 * LOG_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*X_WDTH-1:0]   y,
  input  logic                  y_nd,
  input  logic [M_WDTH-1:0]     m_in,
  input  logic                  clear,
  output logic                  wr_en,
  output logic [LOG_N-1:0]      wr_addr,
  output logic [2*X_WDTH-1:0]   wr_data,
  output logic [LOG_N-2:0]      bf_count,
  output logic                  stage_done,
  output logic                  err
);

  localparam int unsigned M_ADDR_A_LSB = m_addr_a_lsb(LOG_N);
  // N/2 butterflies per stage; the counter is exactly LOG_N-1 bits wide,
  // so the last butterfly index is all ones.
  localparam logic [LOG_N-2:0] LAST_BF = '1;

  bfc_state_t       state, next_state;
  logic             take_a, take_b;
  logic [LOG_N-1:0] addr_a, addr_b;
  logic [LOG_N-1:0] addr_b_p0;
  logic             last_bf;

  assign addr_a  = m_in[M_ADDR_A_LSB +: LOG_N];
  assign addr_b  = m_in[M_ADDR_B_LSB +: LOG_N];
  assign last_bf = (bf_count == LAST_BF);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and write selection; clear aborts any pair in flight and
  // drops a y_nd seen in the same cycle. A y_nd while expecting YB is not
  // treated as a new YA: the sample goes out as YB and the FSM idles.
  always_comb begin
    next_state = state;
    take_a     = 1'b0;
    take_b     = 1'b0;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (y_nd) begin
            take_a     = 1'b1;
            next_state = EXPECT_B;
          end
        end
        EXPECT_B: begin
          take_b     = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Write register, butterfly counter, stage_done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      addr_b_p0  <= '0;
      bf_count   <= '0;
      stage_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= take_a | take_b;
      stage_done <= take_b & last_bf;
      if (take_a) begin
        wr_addr   <= addr_a;
        wr_data   <= y;
        addr_b_p0 <= addr_b;
      end
      if (take_b) begin
        wr_addr  <= addr_b_p0;
        wr_data  <= y;
        bf_count <= last_bf ? '0 : bf_count + 1'b1;
        if (y_nd) err <= 1'b1;
      end
      if (clear) bf_count <= '0;
    end
  end

endmodule
